// File: rtl/tag_anc_pkg.sv
// Shared types and default widths for the tag phase scheduler.
package tag_anc_pkg;

    localparam int DEF_PHASE_WIDTH = 24;
    localparam int DEF_NSYMB_WIDTH = 16;
    localparam int DEF_NLOC_WIDTH  = 3;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sched_state_e;

    // Operations the sequencer requests from the phase accumulator.
    typedef enum logic [2:0] {
        ACC_HOLD      = 3'd0,
        ACC_LOAD      = 3'd1,
        ACC_NEXT_SIG  = 3'd2,
        ACC_NEXT_SYMB = 3'd3,
        ACC_NEXT_LOC  = 3'd4
    } acc_op_e;

endpackage

// File: rtl/tag_phase_acc.sv
// Phase accumulator: phase, increment and symbol-start registers plus the
// configuration values they are rebuilt from. All arithmetic wraps at
// 2^PHASE_WIDTH.
module tag_phase_acc
    import tag_anc_pkg::*;
#(
    parameter int PHASE_WIDTH = DEF_PHASE_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  acc_op_e                i_op,
    input  logic [PHASE_WIDTH-1:0] i_cfg_start_ph,
    input  logic [PHASE_WIDTH-1:0] i_cfg_start_ph_inc,
    input  logic [PHASE_WIDTH-1:0] i_cfg_dph_inc,
    input  logic [PHASE_WIDTH-1:0] i_cfg_nph_shift,
    output logic [PHASE_WIDTH-1:0] o_phase
);

    logic [PHASE_WIDTH-1:0] r_phase;
    logic [PHASE_WIDTH-1:0] r_inc;
    logic [PHASE_WIDTH-1:0] r_symb_start;
    logic [PHASE_WIDTH-1:0] r_start_ph;
    logic [PHASE_WIDTH-1:0] r_start_inc;
    logic [PHASE_WIDTH-1:0] r_dph_inc;
    logic [PHASE_WIDTH-1:0] r_nph_shift;

    logic [PHASE_WIDTH-1:0] w_symb_start_dec;

    // Each new symbol starts nph_shift below the previous symbol's start,
    // which equals start_ph - symb_n*nph_shift without a multiplier.
    assign w_symb_start_dec = r_symb_start - r_nph_shift;

    // Register update selected by the sequencer's requested operation.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_phase      <= '0;
            r_inc        <= '0;
            r_symb_start <= '0;
            r_start_ph   <= '0;
            r_start_inc  <= '0;
            r_dph_inc    <= '0;
            r_nph_shift  <= '0;
        end else begin
            case (i_op)
                ACC_LOAD: begin
                    r_start_ph   <= i_cfg_start_ph;
                    r_start_inc  <= i_cfg_start_ph_inc;
                    r_dph_inc    <= i_cfg_dph_inc;
                    r_nph_shift  <= i_cfg_nph_shift;
                    r_phase      <= i_cfg_start_ph;
                    r_inc        <= i_cfg_start_ph_inc;
                    r_symb_start <= i_cfg_start_ph;
                end
                ACC_NEXT_SIG: begin
                    r_phase <= r_phase + r_inc;
                end
                ACC_NEXT_SYMB: begin
                    r_symb_start <= w_symb_start_dec;
                    r_phase      <= w_symb_start_dec;
                    r_inc        <= r_inc + r_dph_inc;
                end
                ACC_NEXT_LOC: begin
                    r_phase      <= r_start_ph;
                    r_inc        <= r_start_inc;
                    r_symb_start <= r_start_ph;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_phase = r_phase;

endmodule

// File: rtl/tag_phase_sched.sv
// Tag phase scheduler: streams nloc repetitions of nsymb symbols, each of
// nsig phase samples, over an AXI-Stream master.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | waiting for start; config sampled when start is accepted
//   RUN     | streaming samples; counters advance on each transfer
//   DONE    | one-cycle completion pulse; sync_ready set, then IDLE
module tag_phase_sched
    import tag_anc_pkg::*;
#(
    parameter int PHASE_WIDTH = DEF_PHASE_WIDTH,
    parameter int NSYMB_WIDTH = DEF_NSYMB_WIDTH,
    parameter int NLOC_WIDTH  = DEF_NLOC_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [PHASE_WIDTH-1:0] cfg_nsig,
    input  logic [NSYMB_WIDTH-1:0] cfg_nsymb,
    input  logic [NLOC_WIDTH-1:0]  cfg_nloc,
    input  logic [PHASE_WIDTH-1:0] cfg_start_ph,
    input  logic [PHASE_WIDTH-1:0] cfg_start_ph_inc,
    input  logic [PHASE_WIDTH-1:0] cfg_dph_inc,
    input  logic [PHASE_WIDTH-1:0] cfg_nph_shift,
    output logic [PHASE_WIDTH-1:0] phase_tdata,
    output logic                   phase_tvalid,
    output logic                   phase_tlast,
    input  logic                   phase_tready,
    output logic                   busy,
    output logic                   done,
    output logic                   cfg_err,
    output logic                   sync_ready,
    output logic [PHASE_WIDTH-1:0] sig_n,
    output logic [NSYMB_WIDTH-1:0] symb_n,
    output logic [NLOC_WIDTH-1:0]  loc_n
);

    sched_state_e r_state;
    sched_state_e w_state_next;
    acc_op_e      w_acc_op;

    logic [PHASE_WIDTH-1:0] r_nsig;
    logic [NSYMB_WIDTH-1:0] r_nsymb;
    logic [NLOC_WIDTH-1:0]  r_nloc;
    logic [PHASE_WIDTH-1:0] r_sig_n;
    logic [NSYMB_WIDTH-1:0] r_symb_n;
    logic [NLOC_WIDTH-1:0]  r_loc_n;
    logic                   r_sync_ready;
    logic                   r_cfg_err;

    logic                   w_cfg_ok;
    logic                   w_start_ok;
    logic                   w_start_bad;
    logic                   w_xfer;
    logic                   w_sig_last;
    logic                   w_symb_last;
    logic [NLOC_WIDTH-1:0]  w_loc_inc;
    logic                   w_loc_last;

    assign w_cfg_ok    = (cfg_nsig != '0) && (cfg_nsymb != '0) && (cfg_nloc != '0);
    // Abort takes priority over a simultaneous start.
    assign w_start_ok  = (r_state == ST_IDLE) && start && !abort && w_cfg_ok;
    assign w_start_bad = (r_state == ST_IDLE) && start && !abort && !w_cfg_ok;
    assign w_xfer      = (r_state == ST_RUN) && phase_tready && !abort;
    assign w_sig_last  = (r_sig_n == r_nsig);
    assign w_symb_last = (r_symb_n == r_nsymb);
    assign w_loc_inc   = r_loc_n + NLOC_WIDTH'(1);
    assign w_loc_last  = (w_loc_inc == r_nloc);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and accumulator operation select.
    always_comb begin
        w_state_next = r_state;
        w_acc_op     = ACC_HOLD;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_state_next = ST_RUN;
                    w_acc_op     = ACC_LOAD;
                end
            end
            ST_RUN: begin
                if (w_xfer) begin
                    if (!w_sig_last) begin
                        w_acc_op = ACC_NEXT_SIG;
                    end else if (!w_symb_last) begin
                        w_acc_op = ACC_NEXT_SYMB;
                    end else begin
                        w_acc_op = ACC_NEXT_LOC;
                        if (w_loc_last) begin
                            w_state_next = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        if (abort) begin
            w_state_next = ST_IDLE;
            w_acc_op     = ACC_HOLD;
        end
    end

    // Config latch and sample/symbol/location counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_nsig   <= '0;
            r_nsymb  <= '0;
            r_nloc   <= '0;
            r_sig_n  <= PHASE_WIDTH'(1);
            r_symb_n <= NSYMB_WIDTH'(1);
            r_loc_n  <= '0;
        end else if (w_start_ok) begin
            r_nsig   <= cfg_nsig;
            r_nsymb  <= cfg_nsymb;
            r_nloc   <= cfg_nloc;
            r_sig_n  <= PHASE_WIDTH'(1);
            r_symb_n <= NSYMB_WIDTH'(1);
            r_loc_n  <= '0;
        end else if (w_xfer) begin
            if (!w_sig_last) begin
                r_sig_n <= r_sig_n + PHASE_WIDTH'(1);
            end else if (!w_symb_last) begin
                r_sig_n  <= PHASE_WIDTH'(1);
                r_symb_n <= r_symb_n + NSYMB_WIDTH'(1);
            end else begin
                r_sig_n  <= PHASE_WIDTH'(1);
                r_symb_n <= NSYMB_WIDTH'(1);
                r_loc_n  <= w_loc_inc;
            end
        end
    end

    // sync_ready rises with DONE and holds until the next accepted start.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync_ready <= 1'b0;
        end else if (w_start_ok) begin
            r_sync_ready <= 1'b0;
        end else if ((r_state == ST_RUN) && (w_state_next == ST_DONE)) begin
            r_sync_ready <= 1'b1;
        end
    end

    // One-cycle error pulse for a start with a zero count.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= w_start_bad;
        end
    end

    tag_phase_acc #(
        .PHASE_WIDTH (PHASE_WIDTH)
    ) u_acc (
        .clk                (clk),
        .reset_n            (reset_n),
        .i_op               (w_acc_op),
        .i_cfg_start_ph     (cfg_start_ph),
        .i_cfg_start_ph_inc (cfg_start_ph_inc),
        .i_cfg_dph_inc      (cfg_dph_inc),
        .i_cfg_nph_shift    (cfg_nph_shift),
        .o_phase            (phase_tdata)
    );

    assign busy         = (r_state == ST_RUN);
    assign phase_tvalid = busy;
    assign phase_tlast  = busy && w_sig_last;
    assign done         = (r_state == ST_DONE);
    assign cfg_err      = r_cfg_err;
    assign sync_ready   = r_sync_ready;
    assign sig_n        = r_sig_n;
    assign symb_n       = r_symb_n;
    assign loc_n        = r_loc_n;

endmodule

// File: tb/tb_tag_phase_sched.sv
// Self-checking bench for tag_phase_sched with a sample-list reference model.
module tb_tag_phase_sched;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [23:0] cfg_nsig = '0;
    logic [15:0] cfg_nsymb = '0;
    logic [2:0]  cfg_nloc = '0;
    logic [23:0] cfg_start_ph = '0;
    logic [23:0] cfg_start_ph_inc = '0;
    logic [23:0] cfg_dph_inc = '0;
    logic [23:0] cfg_nph_shift = '0;
    logic [23:0] phase_tdata;
    logic        phase_tvalid;
    logic        phase_tlast;
    logic        phase_tready = 1'b0;
    logic        busy;
    logic        done;
    logic        cfg_err;
    logic        sync_ready;
    logic [23:0] sig_n;
    logic [15:0] symb_n;
    logic [2:0]  loc_n;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [23:0] ph;
        bit          last;
        int          sig;
        int          symb;
        int          loc;
    } samp_t;

    samp_t       exp_q[$];
    logic [23:0] obs_q[$];

    tag_phase_sched dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .abort            (abort),
        .cfg_nsig         (cfg_nsig),
        .cfg_nsymb        (cfg_nsymb),
        .cfg_nloc         (cfg_nloc),
        .cfg_start_ph     (cfg_start_ph),
        .cfg_start_ph_inc (cfg_start_ph_inc),
        .cfg_dph_inc      (cfg_dph_inc),
        .cfg_nph_shift    (cfg_nph_shift),
        .phase_tdata      (phase_tdata),
        .phase_tvalid     (phase_tvalid),
        .phase_tlast      (phase_tlast),
        .phase_tready     (phase_tready),
        .busy             (busy),
        .done             (done),
        .cfg_err          (cfg_err),
        .sync_ready       (sync_ready),
        .sig_n            (sig_n),
        .symb_n           (symb_n),
        .loc_n            (loc_n)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Every sample of the sequence, from the closed-form phase rule:
    // phase(s,k) = start_ph - s*shift + k*(start_inc + s*dph), mod 2^24.
    function automatic void build_model(input int nsig, input int nsymb, input int nloc,
                                        input logic [23:0] sph, input logic [23:0] sinc,
                                        input logic [23:0] dph, input logic [23:0] shift);
        samp_t  s;
        longint inc;
        longint ph;
        exp_q.delete();
        for (int l = 0; l < nloc; l++) begin
            for (int y = 0; y < nsymb; y++) begin
                inc = (longint'(sinc) + longint'(y) * longint'(dph)) & 64'hFFFFFF;
                for (int k = 0; k < nsig; k++) begin
                    ph = longint'(sph) - longint'(y) * longint'(shift) + longint'(k) * inc;
                    s.ph   = 24'(ph & 64'hFFFFFF);
                    s.last = (k == nsig - 1);
                    s.sig  = k + 1;
                    s.symb = y + 1;
                    s.loc  = l;
                    exp_q.push_back(s);
                end
            end
        end
    endfunction

    // mode 0: tready always high; 1: random tready plus start/config noise
    // while running; 2: tready low for 3 cycles while the 2nd sample is shown.
    task automatic run_seq(input int nsig, input int nsymb, input int nloc,
                           input logic [23:0] sph, input logic [23:0] sinc,
                           input logic [23:0] dph, input logic [23:0] shift,
                           input int mode);
        samp_t s;
        int    cyc;
        int    nx;
        int    stall;
        bit    rdy;
        build_model(nsig, nsymb, nloc, sph, sinc, dph, shift);
        obs_q.delete();
        @(negedge clk);
        cfg_nsig         = 24'(nsig);
        cfg_nsymb        = 16'(nsymb);
        cfg_nloc         = 3'(nloc);
        cfg_start_ph     = sph;
        cfg_start_ph_inc = sinc;
        cfg_dph_inc      = dph;
        cfg_nph_shift    = shift;
        start            = 1'b1;
        abort            = 1'b0;
        phase_tready     = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        nx    = 0;
        stall = 0;
        while (exp_q.size() > 0 && cyc < 2000) begin
            s = exp_q[0];
            chk("tvalid", phase_tvalid, 1);
            chk("busy", busy, 1);
            chk("done_in_run", done, 0);
            chk("tdata", phase_tdata, s.ph);
            chk("tlast", phase_tlast, s.last);
            chk("sig_n", sig_n, s.sig);
            chk("symb_n", symb_n, s.symb);
            chk("loc_n", loc_n, s.loc);
            case (mode)
                1: rdy = ($urandom_range(0, 3) != 0);
                2: begin
                    if (nx == 1 && stall < 3) begin
                        rdy = 1'b0;
                        stall++;
                    end else begin
                        rdy = 1'b1;
                    end
                end
                default: rdy = 1'b1;
            endcase
            phase_tready = rdy;
            if (mode == 1) begin
                start            = ($urandom_range(0, 3) == 0);
                cfg_nsig         = 24'($urandom);
                cfg_nsymb        = 16'($urandom);
                cfg_nloc         = 3'($urandom);
                cfg_start_ph     = 24'($urandom);
                cfg_start_ph_inc = 24'($urandom);
                cfg_dph_inc      = 24'($urandom);
                cfg_nph_shift    = 24'($urandom);
            end
            if (rdy) begin
                obs_q.push_back(phase_tdata);
                void'(exp_q.pop_front());
                nx++;
            end
            @(negedge clk);
            cyc++;
        end
        start        = 1'b0;
        phase_tready = 1'b0;
        chk("stream_timeout", exp_q.size(), 0);
        chk("done", done, 1);
        chk("sync_ready_set", sync_ready, 1);
        chk("tvalid_in_done", phase_tvalid, 0);
        chk("busy_in_done", busy, 0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("sync_ready_hold", sync_ready, 1);
    endtask

    // Starts the 4x2x1 reference stream and stops after 3 transfers.
    task automatic start_and_take3();
        @(negedge clk);
        cfg_nsig         = 24'd4;
        cfg_nsymb        = 16'd2;
        cfg_nloc         = 3'd1;
        cfg_start_ph     = 24'h0;
        cfg_start_ph_inc = 24'h100;
        cfg_dph_inc      = 24'h100;
        cfg_nph_shift    = 24'h10;
        start            = 1'b1;
        phase_tready     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        phase_tready = 1'b0;
        chk("pre_abort_tdata", phase_tdata, 24'h300);
        chk("pre_abort_sync", sync_ready, 0);
    endtask

    logic [23:0] exp28[8];

    initial begin
        exp28 = '{24'h000000, 24'h000100, 24'h000200, 24'h000300,
                  24'hFFFFF0, 24'h0001F0, 24'h0003F0, 24'h0005F0};

        repeat (3) @(negedge clk);
        chk("rst_tvalid", phase_tvalid, 0);
        chk("rst_tlast", phase_tlast, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_sync", sync_ready, 0);
        chk("rst_tdata", phase_tdata, 0);
        chk("rst_sig_n", sig_n, 1);
        chk("rst_symb_n", symb_n, 1);
        chk("rst_loc_n", loc_n, 0);
        reset_n = 1'b1;

        // Zero count: error pulse, no streaming.
        @(negedge clk);
        cfg_nsig  = 24'd0;
        cfg_nsymb = 16'd2;
        cfg_nloc  = 3'd1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("cfg_err_pulse", cfg_err, 1);
        chk("cfg_err_tvalid", phase_tvalid, 0);
        chk("cfg_err_busy", busy, 0);
        @(negedge clk);
        chk("cfg_err_clear", cfg_err, 0);
        chk("cfg_err_tvalid2", phase_tvalid, 0);

        // Start together with abort in IDLE is dropped.
        cfg_nsig = 24'd4;
        start    = 1'b1;
        abort    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_tvalid", phase_tvalid, 0);
        chk("start_abort_busy", busy, 0);
        chk("start_abort_err", cfg_err, 0);

        // Reference stream, then the same stream with a stall on sample 2.
        run_seq(4, 2, 1, 24'h0, 24'h100, 24'h100, 24'h10, 0);
        chk("n28", obs_q.size(), 8);
        for (int i = 0; i < obs_q.size() && i < 8; i++) chk("seq28", obs_q[i], exp28[i]);
        run_seq(4, 2, 1, 24'h0, 24'h100, 24'h100, 24'h10, 2);
        chk("n29", obs_q.size(), 8);
        for (int i = 0; i < obs_q.size() && i < 8; i++) chk("seq29", obs_q[i], exp28[i]);

        // One 2-sample symbol repeated over 3 locations.
        run_seq(2, 1, 3, 24'h123456, 24'h000777, 24'h000011, 24'h000022, 0);

        // Abort mid-stream, then restart.
        start_and_take3();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_tvalid", phase_tvalid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_sync", sync_ready, 0);
        @(negedge clk);
        chk("abort_done2", done, 0);
        run_seq(4, 2, 1, 24'h0, 24'h100, 24'h100, 24'h10, 0);

        // Reset mid-stream, then restart.
        start_and_take3();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("mrst_tvalid", phase_tvalid, 0);
        chk("mrst_done", done, 0);
        chk("mrst_sync", sync_ready, 0);
        chk("mrst_tdata", phase_tdata, 0);
        chk("mrst_sig_n", sig_n, 1);
        chk("mrst_loc_n", loc_n, 0);
        @(negedge clk);
        chk("mrst_done2", done, 0);
        run_seq(4, 2, 1, 24'h0, 24'h100, 24'h100, 24'h10, 0);

        // Random configurations with random backpressure and start/config noise.
        for (int t = 0; t < 8; t++) begin
            run_seq($urandom_range(1, 5), $urandom_range(1, 3), $urandom_range(1, 3),
                    24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
